mem_to_com_fsm: RTL and testbench
=================================

MEM_TO_COM_FSM -- requirements
Module: mem_to_com_FSM

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 17, the RAM address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, the RAM word and UART byte width.
REQ-003 The module SHALL have parameter DEPTH, default 76_800, the number of RAM words.
REQ-004 The module SHALL have parameter RD_LATENCY, default 1, the RAM read latency in clk cycles (1..3).
REQ-005 The module SHALL have parameter HDR_BYTE, default 8'hAA, the frame start byte.
REQ-006 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The module SHALL have port i_start, input, 1 bit: dump request, sampled only in IDLE.
REQ-009 The module SHALL have port i_addr_start, input, ADDR_WIDTH bits: first RAM address, latched on start.
REQ-010 The module SHALL have port i_length, input, ADDR_WIDTH bits: number of data bytes, latched on start.
REQ-011 The module SHALL have port o_addr_rd, output, ADDR_WIDTH bits: RAM read address.
REQ-012 The module SHALL have port i_data_rd, input, DATA_WIDTH bits: RAM read data.
REQ-013 The module SHALL have port o_tx_dv, output, 1 bit: one-cycle byte-valid pulse to the UART TX.
REQ-014 The module SHALL have port o_tx_byte, output, DATA_WIDTH bits: byte to transmit.
REQ-015 The module SHALL have port i_tx_active, input, 1 bit: UART TX busy.
REQ-016 The module SHALL have port i_tx_done, input, 1 bit: one-cycle pulse when the UART TX completes a byte.
REQ-017 The module SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-018 The module SHALL have port o_done, output, 1 bit: one-cycle pulse at frame end.
REQ-019 The module SHALL have port o_state, output, 4 bits: current state encoding, for the 7-segment debug display.

Function
REQ-020 The frame SHALL be HDR_BYTE, then i_length data bytes read from RAM in ascending address order, then an 8-bit checksum equal to the sum mod 256 of the data bytes.
REQ-021 The states SHALL be IDLE=0, HEADER=1, RD_ADDR=2, RD_WAIT=3, SEND=4, WAIT_TX=5, CHECKSUM=6, DONE=7.
REQ-022 The block SHALL go IDLE -> HEADER when i_start=1; it SHALL latch i_addr_start and i_length and clear the checksum in the same cycle.
REQ-023 The HEADER, SEND and CHECKSUM states SHALL wait while i_tx_active=1, then pulse o_tx_dv for exactly one cycle with o_tx_byte valid in that cycle, then enter WAIT_TX.
REQ-024 WAIT_TX SHALL hold until i_tx_done=1 and then branch as follows:
- to RD_ADDR if data bytes remain;
- to CHECKSUM if no data bytes remain and the checksum is not yet sent;
- to DONE after the checksum.
REQ-025 RD_ADDR SHALL drive o_addr_rd for one cycle; RD_WAIT SHALL last RD_LATENCY cycles; SEND SHALL capture i_data_rd into o_tx_byte and add it to the checksum.
REQ-026 The address SHALL increment after each data byte and SHALL wrap from DEPTH-1 to 0.
REQ-027 If i_length=0, the frame SHALL be HDR_BYTE followed by checksum 8'h00.
REQ-028 A value of i_length greater than DEPTH SHALL be clamped to DEPTH.
REQ-029 i_start asserted while o_busy=1 SHALL be ignored.
REQ-030 DONE SHALL pulse o_done for one cycle and return to IDLE in the next cycle.
REQ-031 o_tx_dv SHALL never be asserted twice without an intervening i_tx_done.
REQ-032 If i_tx_done arrives in the same cycle as o_tx_dv, the transition SHALL be treated as a fresh WAIT_TX entry; the pulse SHALL NOT be lost.
REQ-033 The checksum accumulator SHALL be 8 bits, with overflow discarded.

Reset
REQ-034 On rst=1 the block SHALL go to IDLE immediately, asynchronously.
REQ-035 Reset values SHALL be:
- o_tx_dv=0, o_done=0, o_busy=0;
- o_tx_byte=0, o_addr_rd=0, o_state=0;
- checksum, counters and latched parameters = 0.
REQ-036 Reset in the middle of a frame SHALL abort the frame without further o_tx_dv pulses; a byte already inside the UART is not recalled.

Structure
REQ-037 State encodings and HDR_BYTE SHALL reside in the shared header mem_to_com_defs.vh, which is shared with com_to_mem_FSM for command and display decoding.
REQ-038 Address generation, wrap and the RD_LATENCY delay SHALL be implemented in one sub-module, mem_rd_seq.

Verification
REQ-039 Start with addr=0, length=4, RAM={01,02,03,04}, and a TX model with a 10-cycle done delay -> bytes AA,01,02,03,04,0A, then o_done pulses once.
REQ-040 Start with length=0 -> bytes AA,00 only; no RAM reads.
REQ-041 Start with addr=76_798, length=3 -> reads at 76_798, 76_799, 0.
REQ-042 RAM={FF,FF,02} -> checksum 8'h00.
REQ-043 A second i_start during the frame -> ignored; exactly one frame is sent.
REQ-044 rst asserted during the second data byte -> o_busy=0 and o_state=0 immediately; no further o_tx_dv until a new i_start.

Source files
------------

// File: rtl/mem_to_com_fsm_pkg.sv
// Shared definitions for the RAM-to-UART frame dumper: state encodings and frame constants.
// The state codes are also what the 7-segment debug display decodes.
package mem_to_com_fsm_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_HEADER   = 4'd1;
    localparam logic [3:0] ST_RD_ADDR  = 4'd2;
    localparam logic [3:0] ST_RD_WAIT  = 4'd3;
    localparam logic [3:0] ST_SEND     = 4'd4;
    localparam logic [3:0] ST_WAIT_TX  = 4'd5;
    localparam logic [3:0] ST_CHECKSUM = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/mem_to_com_fsm_rd_seq.sv
// mem_rd_seq: RAM read address generator with wrap at DEPTH-1, remaining-byte counter
// and the RD_LATENCY wait counter used by the frame FSM.
module mem_rd_seq #(
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH      = 76_800,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_start_i,
    input  logic [ADDR_WIDTH-1:0] length_i,
    input  logic                  advance_i,
    input  logic                  lat_load_i,
    input  logic                  lat_tick_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  bytes_left_o,
    output logic                  lat_done_o
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
    localparam logic [1:0]            LAT_INIT  = 2'(RD_LATENCY - 1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            lat_q, lat_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        lat_d  = lat_q;
        if (load_i) begin
            addr_d = addr_start_i;
            cnt_d  = (length_i > DEPTH_A) ? DEPTH_A : length_i;
        end else if (advance_i) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE_A;
            cnt_d  = cnt_q - ONE_A;
        end
        // The address is held from RD_ADDR through SEND, so the wait only has to cover latency.
        if (lat_load_i) begin
            lat_d = LAT_INIT;
        end else if (lat_tick_i && (lat_q != 2'd0)) begin
            lat_d = lat_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
            lat_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            lat_q  <= lat_d;
        end
    end

    assign addr_o       = addr_q;
    assign bytes_left_o = (cnt_q != '0);
    assign lat_done_o   = (lat_q == 2'd0);

endmodule

// File: rtl/mem_to_com_fsm.sv
// Dumps a RAM region over a UART TX as a frame: header byte, data bytes, 8-bit additive checksum.
// o_tx_dv is registered and is high in the first WAIT_TX cycle after each HEADER/SEND/CHECKSUM.
module mem_to_com_fsm
    import mem_to_com_fsm_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 76_800,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] HDR_BYTE   = HDR_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_start,
    input  logic [ADDR_WIDTH-1:0] i_length,
    output logic [ADDR_WIDTH-1:0] o_addr_rd,
    input  logic [DATA_WIDTH-1:0] i_data_rd,
    output logic                  o_tx_dv,
    output logic [DATA_WIDTH-1:0] o_tx_byte,
    input  logic                  i_tx_active,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3:0]            o_state
);

    logic [3:0]            state_q, state_d;
    logic [7:0]            cks_q, cks_d;
    logic                  cks_sent_q, cks_sent_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  tx_dv_q, tx_dv_d;
    logic                  load, advance, lat_load, lat_tick;
    logic                  bytes_left, lat_done;

    mem_rd_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_seq (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .addr_start_i (i_addr_start),
        .length_i     (i_length),
        .advance_i    (advance),
        .lat_load_i   (lat_load),
        .lat_tick_i   (lat_tick),
        .addr_o       (o_addr_rd),
        .bytes_left_o (bytes_left),
        .lat_done_o   (lat_done)
    );

    always_comb begin
        state_d    = state_q;
        cks_d      = cks_q;
        cks_sent_d = cks_sent_q;
        tx_byte_d  = tx_byte_q;
        tx_dv_d    = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        lat_load   = 1'b0;
        lat_tick   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    load       = 1'b1;
                    cks_d      = '0;
                    cks_sent_d = 1'b0;
                    state_d    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = HDR_BYTE;
                    state_d   = ST_WAIT_TX;
                end
            end
            ST_RD_ADDR: begin
                lat_load = 1'b1;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_done) state_d = ST_SEND;
                else          lat_tick = 1'b1;
            end
            ST_SEND: begin
                if (!i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = i_data_rd;
                    cks_d     = cks_q + i_data_rd[7:0];
                    advance   = 1'b1;
                    state_d   = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // A done coinciding with our own dv pulse belongs to the previous byte.
                if (i_tx_done && !tx_dv_q) begin
                    if (bytes_left)       state_d = ST_RD_ADDR;
                    else if (!cks_sent_q) state_d = ST_CHECKSUM;
                    else                  state_d = ST_DONE;
                end
            end
            ST_CHECKSUM: begin
                if (!i_tx_active) begin
                    tx_dv_d    = 1'b1;
                    tx_byte_d  = DATA_WIDTH'(cks_q);
                    cks_sent_d = 1'b1;
                    state_d    = ST_WAIT_TX;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cks_q      <= '0;
            cks_sent_q <= 1'b0;
            tx_byte_q  <= '0;
            tx_dv_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cks_q      <= cks_d;
            cks_sent_q <= cks_sent_d;
            tx_byte_q  <= tx_byte_d;
            tx_dv_q    <= tx_dv_d;
        end
    end

    assign o_tx_dv   = tx_dv_q;
    assign o_tx_byte = tx_byte_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = (state_q == ST_DONE);
    assign o_state   = state_q;

endmodule

// File: tb/tb_mem_to_com_fsm.sv
// Bench for mem_to_com_fsm: RAM model, UART TX model with a 10-cycle done delay,
// and a frame-level reference model feeding expected byte and read-address queues.
module tb_mem_to_com_fsm;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 76_800;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_addr_start;
    logic [AW-1:0] i_length;
    logic [AW-1:0] o_addr_rd;
    logic [DW-1:0] i_data_rd;
    logic          o_tx_dv;
    logic [DW-1:0] o_tx_byte;
    logic          i_tx_active;
    logic          i_tx_done;
    logic          o_busy;
    logic          o_done;
    logic [3:0]    o_state;

    always #5 clk = ~clk;

    mem_to_com_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_addr_start (i_addr_start),
        .i_length     (i_length),
        .o_addr_rd    (o_addr_rd),
        .i_data_rd    (i_data_rd),
        .o_tx_dv      (o_tx_dv),
        .o_tx_byte    (o_tx_byte),
        .i_tx_active  (i_tx_active),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_state      (o_state)
    );

    // RAM with one cycle of read latency
    logic [7:0] ram [0:DEPTH-1];
    logic [7:0] rd_pipe;
    always @(posedge clk) rd_pipe <= ram[o_addr_rd];
    assign i_data_rd = rd_pipe;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int done_cnt = 0;
    int dv_cnt   = 0;
    logic [7:0] last_byte = 8'h00;
    int tx_cnt = 0;

    typedef struct {
        int         addr;
        int         len;
        logic [7:0] d[4];
        logic [7:0] cks;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // UART TX model: busy for 10 cycles after each byte, then a one-cycle done pulse
    always @(negedge clk) begin
        bit was_busy;
        was_busy  = (tx_cnt > 0);
        i_tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                i_tx_active = 1'b0;
                i_tx_done   = 1'b1;
            end
        end
        if (o_tx_dv && !rst) begin
            total++;
            if (was_busy) begin
                bad++;
                $display("FAIL dv_while_busy: got=1 expected=0");
            end
            i_tx_active = 1'b1;
            tx_cnt      = 10;
        end
    end

    // Scoreboard: transmitted bytes, RAM read addresses, done pulses
    always @(negedge clk) begin
        logic [DW-1:0] eb;
        logic [AW-1:0] ea;
        if (!rst) begin
            if (o_tx_dv) begin
                dv_cnt++;
                last_byte = o_tx_byte;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_byte: got=%0h expected=none", o_tx_byte);
                end else begin
                    eb = exp_q.pop_front();
                    if (o_tx_byte !== eb) begin
                        bad++;
                        $display("FAIL tx_byte: got=%0h expected=%0h", o_tx_byte, eb);
                    end
                end
            end
            if (o_state == 4'd2) begin
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_addr: got=%0d expected=none", o_addr_rd);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (o_addr_rd !== ea) begin
                        bad++;
                        $display("FAIL rd_addr: got=%0d expected=%0d", o_addr_rd, ea);
                    end
                end
            end
            if (o_done) done_cnt++;
        end
    end

    // Reference frame: header, data in ascending wrapped order, sum mod 256
    task automatic model_frame(input int a, input int n);
        int nn;
        int sum;
        int idx;
        nn  = (n > DEPTH) ? DEPTH : n;
        sum = 0;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < nn; i++) begin
            idx = (a + i) % DEPTH;
            exp_q.push_back(ram[idx]);
            exp_addr_q.push_back(AW'(idx));
            sum = (sum + int'(ram[idx])) % 256;
        end
        exp_q.push_back(8'(sum));
    endtask

    task automatic run_frame(input int a, input int n, input bit dup);
        int d0;
        int budget;
        model_frame(a, n);
        budget = (n + 3) * 30 + 50;
        d0 = done_cnt;
        @(negedge clk);
        i_addr_start = AW'(a);
        i_length     = AW'(n);
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < budget && done_cnt == d0; c++) begin
            @(negedge clk);
            i_start = dup && (c == 20);
            if (dup && c == 20) begin
                i_addr_start = AW'($urandom_range(0, DEPTH - 1));
                i_length     = AW'($urandom_range(1, 9));
            end
        end
        i_start = 1'b0;
        repeat (30) @(negedge clk);
        check("done_once", done_cnt, d0 + 1);
        check("bytes_left_in_queue", exp_q.size(), 0);
        check("reads_left_in_queue", exp_addr_q.size(), 0);
        check("idle_after_frame", {o_busy, o_state}, 5'd0);
    endtask

    initial begin
        int d0;
        int a;
        int n;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
        rst          = 1'b1;
        i_start      = 1'b0;
        i_addr_start = '0;
        i_length     = '0;
        i_tx_active  = 1'b0;
        i_tx_done    = 1'b0;

        vecs[0] = '{addr: 0,         len: 4, d: '{8'h01, 8'h02, 8'h03, 8'h04}, cks: 8'h0A};
        vecs[1] = '{addr: 50,        len: 0, d: '{8'h11, 8'h22, 8'h33, 8'h44}, cks: 8'h00};
        vecs[2] = '{addr: DEPTH - 2, len: 3, d: '{8'hFF, 8'hFF, 8'h02, 8'h00}, cks: 8'h00};
        vecs[3] = '{addr: 200,       len: 2, d: '{8'h80, 8'h80, 8'h00, 8'h00}, cks: 8'h00};
        vecs[4] = '{addr: 300,       len: 3, d: '{8'h10, 8'h20, 8'h30, 8'h00}, cks: 8'h60};
        vecs[5] = '{addr: 1000,      len: 1, d: '{8'h7F, 8'h00, 8'h00, 8'h00}, cks: 8'h7F};

        repeat (3) @(negedge clk);
        check("rst_tx_dv",   o_tx_dv,   0);
        check("rst_done",    o_done,    0);
        check("rst_busy",    o_busy,    0);
        check("rst_tx_byte", o_tx_byte, 0);
        check("rst_addr_rd", o_addr_rd, 0);
        check("rst_state",   o_state,   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].len; i++) ram[(vecs[v].addr + i) % DEPTH] = vecs[v].d[i];
            run_frame(vecs[v].addr, vecs[v].len, 1'b0);
            check("table_checksum", last_byte, vecs[v].cks);
        end

        // second start while busy must not begin another frame
        run_frame(4000, 5, 1'b1);

        for (int k = 0; k < 6; k++) begin
            a = (k % 2 == 0) ? DEPTH - 1 - $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1);
            n = $urandom_range(0, 12);
            run_frame(a, n, 1'b0);
        end

        // reset while the second data byte is in flight
        model_frame(500, 4);
        d0 = dv_cnt;
        @(negedge clk);
        i_addr_start = AW'(500);
        i_length     = AW'(4);
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 200 && dv_cnt < d0 + 3; c++) @(negedge clk);
        check("reached_second_data_byte", dv_cnt >= d0 + 3, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy",  o_busy,  0);
        check("abort_state", o_state, 0);
        check("abort_tx_dv", o_tx_dv, 0);
        exp_q.delete();
        exp_addr_q.delete();
        d0 = dv_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no_dv_after_abort", dv_cnt, d0);
        check("idle_after_abort", o_busy, 0);

        run_frame(10, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
